seq_barrel_shifter: RTL and testbench
=====================================

// Module: seq_barrel_shifter
// PURPOSE
//  Parametrised multi-position shifter. Successor to the one-position 4-bit shifter cell.
//  Accepts a word plus a shift amount, direction and mode. Shifts one position per clock
//  by iterating a one-step shifter cell.
//  Uses valid/ready handshakes on both sides; sits between the operand registers and the
//  result bus of the datapath.
// PARAMETERS
//  WIDTH  8  data width; power of two, >= 2
//  AMT_W  $clog2(WIDTH)+1  width of the shift-amount field (derived; do not override)
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       request present
//  in_ready   out  1       block can accept request (high only in IDLE)
//  in_data    in   WIDTH   operand
//  in_amt     in   AMT_W   requested shift distance
//  in_dir     in   1       0 = left, 1 = right
//  in_mode    in   2       00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//  out_valid  out  1       result present (high only in DONE)
//  out_ready  in   1       consumer takes result
//  out_data   out  WIDTH   result word
//  busy       out  1       high in SHIFT or DONE
// BEHAVIOUR
//  Reset: state=IDLE, out_data=0, out_valid=0, busy=0, in_ready=1, internal counter=0.
//  Reset has priority over every other event, including mid-SHIFT and in DONE.
//  Reset abandons the operation; no result is emitted.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&in_ready, latch data/dir/mode and set cnt = effective amount.
//     Go to DONE if cnt==0, else go to SHIFT.
//   SHIFT: each cycle apply one step to the held word and decrement cnt.
//     Go to DONE on the step taken with cnt==1. in_valid is ignored.
//   DONE: out_valid=1. out_data is held stable until out_ready=1, then go to IDLE.
//  Latency: out_valid rises eff_amt cycles after the accepting edge (eff_amt=0: next cycle).
//  Throughput: one request per eff_amt+2 cycles minimum. There is no accept while in DONE.
//  Effective amount:
//   logical/arithmetic: min(in_amt, WIDTH), so larger amounts cost at most WIDTH cycles.
//   rotate: in_amt mod WIDTH, i.e. the low $clog2(WIDTH) bits.
//  One-step rules (left / right):
//   logical: fill the vacated bit with 0.
//   arithmetic: left == logical left; right replicates the MSB.
//   rotate: the bit leaving one end enters the other end.
//  out_data is written only when latching (raw in_data) and on SHIFT steps.
//  In IDLE, out_data keeps the last result.
//  Handshake: out_valid must not drop without out_ready. in_ready is a pure function of state.
// STRUCTURE
//  Package shift_pkg holds:
//   typedef enum logic[1:0] shift_mode_e {SH_LOGIC, SH_ARITH, SH_ROT, SH_RSVD}
//   typedef enum logic[1:0] shift_state_e {ST_IDLE, ST_SHIFT, ST_DONE}
//   localparam DIR_LEFT=1'b0, DIR_RIGHT=1'b1
//  Sub-module shift_one_step #(WIDTH): purely combinational one-position step (dir, mode -> o).
//  The top level owns the FSM, the counter, the held word and the handshake.
// TESTING (WIDTH=8)
//  1. Logical left, 8'b1011_0011, amt 3 -> out_data 8'b1001_1000.
//     out_valid 3 cycles after accept; busy high throughout.
//  2. Arithmetic right, 8'hA4, amt 2 -> 8'hE9.
//     Arithmetic right, 8'h24, amt 2 -> 8'h09.
//  3. Rotate right, 8'h81, amt 9 -> eff 1 -> 8'hC0 after 1 cycle.
//     Rotate left, 8'h81, amt 8 -> 8'h81 next cycle.
//  4. Logical left, amt 0, 8'h5A -> 8'h5A with out_valid one cycle after accept.
//     Logical right, amt 12, 8'hFF -> 8'h00 after exactly 8 cycles.
//  5. Backpressure: out_ready low 5 cycles in DONE -> out_data/out_valid stable.
//     in_ready=0 and a concurrent in_valid is not accepted. out_ready=1 -> IDLE next cycle.
//  6. rst asserted on 2nd SHIFT cycle of a logical left, 8'hFF, amt 6.
//     Next cycle: out_valid=0, busy=0, in_ready=1, out_data=0. A new request is then served correctly.

Source files
------------

// File: rtl/seq_barrel_shifter_pkg.sv
// Shared types and constants for the sequential barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LOGIC = 2'b00,
        SH_ARITH = 2'b01,
        SH_ROT   = 2'b10,
        SH_RSVD  = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_barrel_shifter_if.sv
// Request/result handshake bundle for the sequential barrel shifter.
interface seq_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    // Shifter side
    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    // Requester / consumer side
    modport master (
        output in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/seq_barrel_shifter_step.sv
// One-position shift cell: logical, arithmetic or rotate, left or right.
module shift_one_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    input  shift_mode_e      i_mode,
    output logic [WIDTH-1:0] o_data
);

    // Shift by one and choose what enters the vacated bit
    always_comb begin
        o_data = i_data;
        if (i_dir == DIR_LEFT) begin
            o_data = {i_data[WIDTH-2:0], 1'b0};
            if (i_mode == SH_ROT) begin
                o_data[0] = i_data[WIDTH-1];
            end
        end else begin
            o_data = {1'b0, i_data[WIDTH-1:1]};
            case (i_mode)
                SH_ARITH: o_data[WIDTH-1] = i_data[WIDTH-1];
                SH_ROT:   o_data[WIDTH-1] = i_data[0];
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Multi-position shifter: iterates a one-step cell once per clock, valid/ready on both sides.
module seq_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    seq_barrel_shifter_if.slave bus
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int AMT_W = SH_W + 1;

    shift_state_e     r_state;
    shift_state_e     w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_step;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_eff;
    logic             r_dir;
    shift_mode_e      r_mode;
    shift_mode_e      w_mode_in;
    logic             w_accept;

    assign w_mode_in = shift_mode_e'(bus.in_mode);
    assign w_accept  = (r_state == ST_IDLE) && bus.in_valid;

    // Effective step count: clamp to WIDTH, or modulo WIDTH for rotate
    always_comb begin
        w_eff = (bus.in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.in_amt;
        if (w_mode_in == SH_ROT) begin
            w_eff = {1'b0, bus.in_amt[SH_W-1:0]};
        end
    end

    shift_one_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_data(r_data),
        .i_dir (r_dir),
        .i_mode(r_mode),
        .o_data(w_step)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = (w_eff == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held word and step counter: load on accept, advance on each SHIFT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_dir  <= DIR_LEFT;
            r_mode <= SH_LOGIC;
        end else if (w_accept) begin
            r_data <= bus.in_data;
            r_cnt  <= w_eff;
            r_dir  <= bus.in_dir;
            r_mode <= w_mode_in;
        end else if (r_state == ST_SHIFT) begin
            r_data <= w_step;
            r_cnt  <= r_cnt - AMT_W'(1);
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign bus.out_data  = r_data;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Bench for seq_barrel_shifter: directed literal cases plus a random run against a reference model.
module tb_seq_barrel_shifter;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_barrel_shifter_if #(.WIDTH(W)) bus ();

    seq_barrel_shifter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of single-position steps a request takes
    function automatic int eff_amt(input logic [AW-1:0] a, input logic [1:0] m);
        if (m == 2'b10) return int'(a) % W;
        return (int'(a) > W) ? W : int'(a);
    endfunction

    // Result of shifting d by k positions, computed directly with shift operators
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int k,
                                               input logic dir, input logic [1:0] m);
        logic signed [W-1:0] s;
        logic [W-1:0] r;
        int kk;
        s = d;
        if (m == 2'b10) begin
            kk = k % W;
            if (dir == 1'b0) r = (d << kk) | (d >> (W - kk));
            else             r = (d >> kk) | (d << (W - kk));
        end else if (dir == 1'b0) begin
            r = (k >= W) ? '0 : (d << k);
        end else if (m == 2'b01) begin
            r = (k >= W) ? {W{d[W-1]}} : $unsigned(s >>> k);
        end else begin
            r = (k >= W) ? '0 : (d >> k);
        end
        return r;
    endfunction

    // Reference model: 0 = accepting, 1 = working, 2 = result offered
    int           m_phase = 0;
    int           m_eff   = 0;
    int           m_steps = 0;
    logic [W-1:0] m_out   = '0;
    logic [W-1:0] m_data  = '0;
    logic         m_dir   = 1'b0;
    logic [1:0]   m_mode  = 2'b00;
    bit           chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_out   = '0;
            m_steps = 0;
            chk_en  = 1'b1;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_data  = bus.in_data;
                    m_dir   = bus.in_dir;
                    m_mode  = bus.in_mode;
                    m_eff   = eff_amt(bus.in_amt, bus.in_mode);
                    m_steps = 0;
                    m_out   = bus.in_data;
                    m_phase = (m_eff == 0) ? 2 : 1;
                end
                1: begin
                    m_steps++;
                    m_out = ref_shift(m_data, m_steps, m_dir, m_mode);
                    if (m_steps == m_eff) m_phase = 2;
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_phase == 0});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_phase == 2});
            chk("busy",      {31'd0, bus.busy},      {31'd0, m_phase != 0});
            chk("out_data",  {24'd0, bus.out_data},  {24'd0, m_out});
        end
    end

    // Issue one request with out_ready high; check result literal and edges-to-valid
    task automatic run_op(input string nm, input logic [7:0] d, input logic [3:0] a,
                          input logic dir, input logic [1:0] m,
                          input logic [7:0] exp, input int exp_lat);
        int  lat;
        bit  seen;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dir;
        bus.in_mode  = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!seen) lat = 99;
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " data"}, {24'd0, bus.out_data}, {24'd0, exp});
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_data",  {24'd0, bus.out_data}, 32'h0);
        chk("reset in_ready",  {31'd0, bus.in_ready}, 32'h1);
        chk("reset busy",      {31'd0, bus.busy},     32'h0);
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("lsl3 B3",    8'hB3, 4'd3,  1'b0, 2'b00, 8'h98, 3);
        run_op("asr2 A4",    8'hA4, 4'd2,  1'b1, 2'b01, 8'hE9, 2);
        run_op("asr2 24",    8'h24, 4'd2,  1'b1, 2'b01, 8'h09, 2);
        run_op("ror9 81",    8'h81, 4'd9,  1'b1, 2'b10, 8'hC0, 1);
        run_op("rol8 81",    8'h81, 4'd8,  1'b0, 2'b10, 8'h81, 0);
        run_op("lsl0 5A",    8'h5A, 4'd0,  1'b0, 2'b00, 8'h5A, 0);
        run_op("lsr12 FF",   8'hFF, 4'd12, 1'b1, 2'b00, 8'h00, 8);
        run_op("mode3 F0",   8'hF0, 4'd2,  1'b1, 2'b11, 8'h3C, 2);
        run_op("asl15 81",   8'h81, 4'd15, 1'b0, 2'b01, 8'h00, 8);

        // Backpressure: result must hold and a competing request must wait
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h3C;
        bus.in_amt    = 4'd2;
        bus.in_dir    = 1'b1;
        bus.in_mode   = 2'b00;
        @(posedge clk); #1;
        bus.in_data   = 8'hAA;
        bus.in_amt    = 4'd1;
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", {31'd0, bus.out_valid}, 32'h1);
            chk("bp out_data",  {24'd0, bus.out_data},  32'h0F);
            chk("bp in_ready",  {31'd0, bus.in_ready},  32'h0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp release in_ready",  {31'd0, bus.in_ready},  32'h1);
        chk("bp release out_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("bp release busy",      {31'd0, bus.busy},      32'h0);
        @(posedge clk); #1;

        // Reset during the second SHIFT cycle abandons the operation
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_amt   = 4'd6;
        bus.in_dir   = 1'b0;
        bus.in_mode  = 2'b00;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("midrst busy",      {31'd0, bus.busy},      32'h0);
        chk("midrst in_ready",  {31'd0, bus.in_ready},  32'h1);
        chk("midrst out_data",  {24'd0, bus.out_data},  32'h0);
        run_op("post-rst asr3 90", 8'h90, 4'd3, 1'b1, 2'b01, 8'hF2, 3);

        // Random traffic with stalls and occasional resets, checked by the model
        for (int c = 0; c < 4000; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 8'($urandom);
            bus.in_amt    = 4'($urandom_range(0, 15));
            bus.in_dir    = 1'($urandom_range(0, 1));
            bus.in_mode   = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
